// File: rtl/note_player.sv
// note_player: plays one note at a time as a fractional-N square wave.
// A note (frequency in centi-Hz, duration in ms) is taken over a valid/ready
// handshake, played for its duration, followed by a silent articulation gap,
// and completion is flagged with a one-cycle done pulse.
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous reset, active low
//   note_freq   in   [31:0] tone frequency, centi-Hz
//   note_dur    in   [15:0] duration, ms
//   note_valid  in   upstream has a note
//   note_ready  out  block can accept a note (IDLE and no stop)
//   stop        in   synchronous abort
//   tone_out    out  square-wave output
//   busy        out  high while playing or in the gap
//   done        out  one-cycle pulse at note completion
module note_player #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned GAP_MS   = 10,
  parameter int unsigned REST_MAX = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] note_freq,
  input  logic [15:0] note_dur,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic        stop,
  output logic        tone_out,
  output logic        busy,
  output logic        done
);

  // Accumulator modulus: one half-period of a 1 centi-Hz tone is CLK_HZ*50
  // cycles, so adding freq (centi-Hz) each cycle and toggling on wrap gives
  // the requested frequency.
  localparam logic [32:0] K        = 33'(64'(CLK_HZ) * 64'd50);
  localparam logic [31:0] MS_CYC   = 32'(CLK_HZ / 1000);
  localparam logic [15:0] GAP_N    = 16'(GAP_MS);
  localparam logic [31:0] REST_LIM = 32'(REST_MAX);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

  state_e      state_q;
  logic [31:0] freq_q;
  logic [15:0] dur_q;
  logic [31:0] acc_q, acc_d;
  logic [31:0] pre_q;
  logic [15:0] ms_q;
  logic        tone_q, tone_d;
  logic        busy_q;
  logic        done_q;

  logic [32:0] sum;
  logic        ms_tick;
  logic        play_end;
  logic        gap_end;

  assign sum      = {1'b0, acc_q} + {1'b0, freq_q};
  assign ms_tick  = (pre_q == MS_CYC - 32'd1);
  assign play_end = ms_tick && (ms_q == dur_q - 16'd1);
  assign gap_end  = ms_tick && (ms_q == GAP_N - 16'd1);

  // Phase accumulator step for one PLAY cycle.
  always_comb begin
    acc_d  = acc_q;
    tone_d = tone_q;
    if (freq_q <= REST_LIM) begin
      // rest: phase frozen, output silent
      tone_d = 1'b0;
    end else if ({1'b0, freq_q} >= K) begin
      // above Nyquist of the accumulator: toggle every cycle
      acc_d  = '0;
      tone_d = ~tone_q;
    end else if (sum >= K) begin
      acc_d  = 32'(sum - K);
      tone_d = ~tone_q;
    end else begin
      acc_d  = sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      freq_q  <= '0;
      dur_q   <= '0;
      acc_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        // abort wins over everything, including a pending accept
        state_q <= IDLE;
        acc_q   <= '0;
        pre_q   <= '0;
        ms_q    <= '0;
        tone_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (note_valid) begin
              freq_q <= note_freq;
              dur_q  <= note_dur;
              acc_q  <= '0;
              pre_q  <= '0;
              ms_q   <= '0;
              tone_q <= 1'b0;
              if (note_dur == 16'd0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= PLAY;
                busy_q  <= 1'b1;
              end
            end
          end
          PLAY: begin
            acc_q  <= acc_d;
            tone_q <= tone_d;
            if (ms_tick) begin
              pre_q <= '0;
              ms_q  <= ms_q + 16'd1;
            end else begin
              pre_q <= pre_q + 32'd1;
            end
            if (play_end) begin
              ms_q   <= '0;
              acc_q  <= '0;
              tone_q <= 1'b0;
              if (GAP_MS == 0) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= GAP;
              end
            end
          end
          GAP: begin
            tone_q <= 1'b0;
            if (ms_tick) begin
              pre_q <= '0;
              ms_q  <= ms_q + 16'd1;
            end else begin
              pre_q <= pre_q + 32'd1;
            end
            if (gap_end) begin
              ms_q    <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_ready = (state_q == IDLE) & ~stop;
  assign tone_out   = tone_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
